// File: rtl/hdmi_period_sequencer.sv
// TMDS period sequencer: raster counters, period classification, buffer rotation, registered syncs.
// Optional output port de is enabled by defining HDMI_DE_OUT_EN.
module hdmi_period_sequencer #(
   parameter int unsigned COL_BITS       = 10,
   parameter int unsigned ROW_BITS       = 10,
   parameter int unsigned H_TOTAL        = 800,
   parameter int unsigned V_TOTAL        = 525,
   parameter int unsigned HS_START       = 16,
   parameter int unsigned HS_END         = 111,
   parameter int unsigned VS_END         = 1,
   parameter int unsigned V_ACTIVE_START = 45,
   parameter int unsigned H_ACTIVE_START = 160,
   parameter int unsigned GUARD_LEN      = 2,
   parameter int unsigned NUM_BUF        = 2,
   localparam int unsigned SEL_W         = $clog2(NUM_BUF)
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                run,
   input  logic                pixel_tick,
   output logic [COL_BITS-1:0] col,
   output logic [ROW_BITS-1:0] row,
   output logic [NUM_BUF-1:0]  shift_load,
   output logic [SEL_W-1:0]    shift_sel,
   output logic [1:0]          period_sel,
   output logic                n_hsync,
   output logic                n_vsync,
   output logic                frame_start,
   output logic                tick_overrun
`ifdef HDMI_DE_OUT_EN
   ,
   output logic                de
`endif
);

   localparam logic [0:0] S_WAIT = 1'b0;
   localparam logic [0:0] S_EMIT = 1'b1;

   localparam logic [COL_BITS-1:0] L_COL_LAST = COL_BITS'(H_TOTAL - 1);
   localparam logic [ROW_BITS-1:0] L_ROW_LAST = ROW_BITS'(V_TOTAL - 1);
   localparam logic [COL_BITS-1:0] L_HS_START = COL_BITS'(HS_START);
   localparam logic [COL_BITS-1:0] L_HS_END   = COL_BITS'(HS_END);
   localparam logic [ROW_BITS-1:0] L_VS_END   = ROW_BITS'(VS_END);
   localparam logic [ROW_BITS-1:0] L_V_ACT    = ROW_BITS'(V_ACTIVE_START);
   localparam logic [COL_BITS-1:0] L_H_ACT    = COL_BITS'(H_ACTIVE_START);
   localparam logic [COL_BITS-1:0] L_GUARD_LO = COL_BITS'(H_ACTIVE_START - GUARD_LEN);
   localparam logic [SEL_W-1:0]    L_BUF_LAST = SEL_W'(NUM_BUF - 1);

   logic [0:0]          r_state;
   logic [0:0]          w_state_nxt;
   logic                w_accept;
   logic                w_emit_done;
   logic [COL_BITS-1:0] r_col;
   logic [ROW_BITS-1:0] r_row;
   logic [COL_BITS-1:0] r_cur_col;
   logic [ROW_BITS-1:0] r_cur_row;
   logic [SEL_W-1:0]    r_buf_idx;
   logic [SEL_W-1:0]    w_buf_nxt;
   logic [NUM_BUF-1:0]  r_shift_load;
   logic [SEL_W-1:0]    r_shift_sel;
   logic [1:0]          r_period_sel;
   logic                r_n_hsync;
   logic                r_n_vsync;
   logic                r_frame_start;
   logic                r_tick_overrun;
   logic [1:0]          w_sync_snap;

   // Sync classes take priority; returns {n_hsync, n_vsync}.
   function automatic logic [1:0] f_sync(input logic [COL_BITS-1:0] c, input logic [ROW_BITS-1:0] r);
      logic hs_col;
      logic vs_row;
      hs_col = (c >= L_HS_START) && (c <= L_HS_END);
      vs_row = (r <= L_VS_END);
      return {~hs_col, ~vs_row};
   endfunction

   // Data-select for a pixel: 00 control/preamble, 01 guard, 10 video.
   function automatic logic [1:0] f_period(input logic [COL_BITS-1:0] c, input logic [ROW_BITS-1:0] r);
      logic [1:0] sel;
      sel = 2'b00;
      if (!((c >= L_HS_START) && (c <= L_HS_END)) && !(r <= L_VS_END) && (r >= L_V_ACT)) begin
         if ((c >= L_GUARD_LO) && (c < L_H_ACT)) begin
            sel = 2'b01;
         end else if (c >= L_H_ACT) begin
            sel = 2'b10;
         end
      end
      return sel;
   endfunction

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= S_WAIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_emit_done = 1'b0;
      case (r_state)
         S_WAIT: begin
            if (pixel_tick && run) begin
               w_state_nxt = S_EMIT;
               w_accept    = 1'b1;
            end
         end
         S_EMIT: begin
            w_state_nxt = S_WAIT;
            w_emit_done = 1'b1;
         end
         default: w_state_nxt = S_WAIT;
      endcase
   end

   assign w_buf_nxt   = (r_buf_idx == L_BUF_LAST) ? '0 : r_buf_idx + SEL_W'(1);
   assign w_sync_snap = f_sync(r_cur_col, r_cur_row);

   // Counters advance when a pixel is accepted; outputs of that pixel appear during EMIT.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_col          <= '0;
         r_row          <= '0;
         r_cur_col      <= '0;
         r_cur_row      <= '0;
         r_buf_idx      <= '0;
         r_shift_load   <= NUM_BUF'(1);
         r_shift_sel    <= L_BUF_LAST;
         r_period_sel   <= 2'b00;
         r_n_hsync      <= 1'b1;
         r_n_vsync      <= 1'b1;
         r_frame_start  <= 1'b0;
         r_tick_overrun <= 1'b0;
      end else begin
         r_shift_sel <= (r_buf_idx == '0) ? L_BUF_LAST : r_buf_idx - SEL_W'(1);
         if (w_accept) begin
            r_cur_col     <= r_col;
            r_cur_row     <= r_row;
            r_period_sel  <= f_period(r_col, r_row);
            r_frame_start <= (r_col == '0) && (r_row == '0);
            if (r_col == L_COL_LAST) begin
               r_col <= '0;
               r_row <= (r_row == L_ROW_LAST) ? '0 : r_row + ROW_BITS'(1);
            end else begin
               r_col <= r_col + COL_BITS'(1);
            end
         end
         if (w_emit_done) begin
            r_period_sel  <= 2'b00;
            r_frame_start <= 1'b0;
            r_n_hsync     <= w_sync_snap[1];
            r_n_vsync     <= w_sync_snap[0];
            r_buf_idx     <= w_buf_nxt;
            r_shift_load  <= NUM_BUF'(1) << w_buf_nxt;
         end
         if ((r_state == S_EMIT) && pixel_tick) begin
            r_tick_overrun <= 1'b1;
         end
      end
   end

`ifdef HDMI_DE_OUT_EN
   logic r_de;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_de <= 1'b0;
      end else if (w_emit_done) begin
         r_de <= (f_period(r_cur_col, r_cur_row) == 2'b10);
      end
   end

   assign de = r_de;
`endif

   assign col          = r_col;
   assign row          = r_row;
   assign shift_load   = r_shift_load;
   assign shift_sel    = r_shift_sel;
   assign period_sel   = r_period_sel;
   assign n_hsync      = r_n_hsync;
   assign n_vsync      = r_n_vsync;
   assign frame_start  = r_frame_start;
   assign tick_overrun = r_tick_overrun;

endmodule
